// File: rtl/data_mem_responder.sv
// Data-memory slave: word-addressed array answering cs/oe/we requests after a fixed
// number of wait states, with ack/busy handshake and error reporting for bad addresses.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter string       MEM_FILE    = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        oe,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, din_q, dout_q;
   logic        wr_q, err_q;

   logic        req_wr, req_rd, req;
   logic        accept, enter_resp;
   logic [31:0] src_addr, src_din;
   logic        src_wr, src_bad, mem_we;
   logic [AW-1:0] src_idx;

   logic [31:0] mem [DEPTH_WORDS];

   // Write wins over read; oe is a don't-care for writes.
   assign req_wr = !cs && we;
   assign req_rd = !cs && !oe && !we;
   assign req    = req_wr || req_rd;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) accept = 1'b1;
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (req) accept = 1'b1;
            else     state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (accept) begin
         if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
         end else begin
            state_d = StWait;
            cnt_d   = CNT_LOAD;
         end
      end
   end

   // With zero wait states the memory acts on the accept edge, so use the live bus.
   always_comb begin
      if (state_q == StWait) begin
         src_addr = addr_q;
         src_din  = din_q;
         src_wr   = wr_q;
      end else begin
         src_addr = addr;
         src_din  = din;
         src_wr   = req_wr;
      end
   end

   assign src_bad = (src_addr[1:0] != 2'b00) || ((src_addr >> (AW + 2)) != 32'd0);
   assign src_idx = src_addr[AW+1:2];
   // Gate with reset so an edge seen while reset is held never commits a write.
   assign mem_we  = enter_resp && src_wr && !src_bad && reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         din_q   <= 32'd0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= addr;
            din_q  <= din;
            wr_q   <= req_wr;
         end
         if (enter_resp) begin
            err_q <= src_bad;
            if (!src_wr && !src_bad) dout_q <= mem[src_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[src_idx] <= src_din;
   end

   assign ack  = (state_q == StResp);
   assign busy = (state_q != StIdle);
   assign err  = ack && err_q;
   assign dout = dout_q;

   a_ack_busy : assert property (@(posedge clk) disable iff (!reset) ack |-> busy);
   a_err_ack  : assert property (@(posedge clk) disable iff (!reset) err |-> ack);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one DUT with two wait states, one with none.
module tb_data_mem_responder;

   typedef struct packed {
      logic        wr;
      logic        err;
      logic [31:0] dout;
   } exp_t;

   logic        clk, reset;
   logic        cs, oe, we, ack, busy, err;
   logic [31:0] addr, din, dout;
   logic        cs0, oe0, we0, ack0, busy0, err0;
   logic [31:0] addr0, din0, dout0;

   int checks = 0;
   int passed = 0;
   exp_t sb[$];
   exp_t sb0[$];
   logic [31:0] model_mem [int];
   logic [31:0] model_dout = 32'd0;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .MEM_FILE("")) dut (
      .clk(clk), .reset(reset), .cs(cs), .oe(oe), .we(we), .addr(addr), .din(din),
      .dout(dout), .ack(ack), .busy(busy), .err(err)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .MEM_FILE("")) dut0 (
      .clk(clk), .reset(reset), .cs(cs0), .oe(oe0), .we(we0), .addr(addr0), .din(din0),
      .dout(dout0), .ack(ack0), .busy(busy0), .err(err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request on the two-wait-state DUT and checks its completion.
   task automatic txn(input logic we_v, input logic oe_v, input logic [31:0] a,
                      input logic [31:0] d, input string name);
      exp_t e;
      logic bad;
      int   n;
      logic got, busy_bad;
      bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
      if (we_v && !bad) model_mem[int'(a[11:2])] = d;
      if (!we_v && !bad) model_dout = model_mem.exists(int'(a[11:2])) ?
                                      model_mem[int'(a[11:2])] : 32'hx;
      @(negedge clk);
      cs = 1'b0; we = we_v; oe = oe_v; addr = a; din = d;
      sb.push_back('{wr: we_v, err: bad, dout: model_dout});
      @(posedge clk);
      #1 cs = 1'b1; we = 1'b0; oe = 1'b1; addr = 32'd0; din = 32'd0;
      n = 0; got = 1'b0; busy_bad = 1'b0;
      while (n < 20 && !got) begin
         @(negedge clk);
         n++;
         if (!busy) busy_bad = 1'b1;
         if (ack) got = 1'b1;
      end
      checks++;
      if (n !== 3 || !got) $display("FAIL %s latency got=%0d (ack=%b) exp=3", name, n, got);
      else passed++;
      checks++;
      if (busy_bad !== 1'b0) $display("FAIL %s busy dropped before ack got=1 exp=0", name);
      else passed++;
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++;
      if (err !== e.err) $display("FAIL %s err got=%b exp=%b", name, err, e.err);
      else passed++;
      checks++;
      if (dout !== e.dout) $display("FAIL %s dout got=%h exp=%h", name, dout, e.dout);
      else passed++;
      @(negedge clk);
      checks++;
      if ({ack, busy, err} !== 3'b000)
         $display("FAIL %s after ack {ack,busy,err} got=%b exp=000", name, {ack, busy, err});
      else passed++;
      checks++;
      if (dout !== e.dout) $display("FAIL %s dout hold got=%h exp=%h", name, dout, e.dout);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cs = 1'b1; oe = 1'b1; we = 1'b0; addr = 32'd0; din = 32'd0;
      cs0 = 1'b1; oe0 = 1'b1; we0 = 1'b0; addr0 = 32'd0; din0 = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ack, busy, err} !== 3'b000)
         $display("FAIL reset outputs got=%b exp=000", {ack, busy, err});
      else passed++;
      checks++;
      if (dout !== 32'd0) $display("FAIL reset dout got=%h exp=00000000", dout);
      else passed++;
      checks++;
      if ({ack0, busy0, err0} !== 3'b000 || dout0 !== 32'd0)
         $display("FAIL reset dut0 got=%b/%h exp=000/00000000", {ack0, busy0, err0}, dout0);
      else passed++;
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, "wr_0x10");
      txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_0x10");
   endtask

   task automatic test_errors();
      txn(1'b1, 1'b1, 32'h0, 32'h0BAD0000, "wr_0x0");
      txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_0x10_again");
      txn(1'b0, 1'b0, 32'h13, 32'h0, "rd_misaligned");
      txn(1'b1, 1'b1, 32'h1000, 32'h12345678, "wr_out_of_range");
      txn(1'b0, 1'b0, 32'h0, 32'h0, "rd_0x0_no_alias");
      txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_0x10_intact");
   endtask

   task automatic test_write_priority();
      txn(1'b1, 1'b0, 32'h8, 32'h55, "wr_oe_low_0x8");
      txn(1'b0, 1'b0, 32'h8, 32'h0, "rd_0x8");
   endtask

   task automatic test_reset_mid();
      logic saw_ack;
      txn(1'b1, 1'b1, 32'h20, 32'hAAAA, "wr_0x20");
      @(negedge clk);
      cs = 1'b0; we = 1'b1; oe = 1'b1; addr = 32'h20; din = 32'h5555;
      @(posedge clk);
      #1 cs = 1'b1; we = 1'b0; addr = 32'd0; din = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      model_dout = 32'd0;
      #1;
      checks++;
      if ({ack, busy, err} !== 3'b000 || dout !== 32'd0)
         $display("FAIL reset_mid outputs got=%b/%h exp=000/00000000", {ack, busy, err}, dout);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      saw_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ack || busy) saw_ack = 1'b1;
      end
      checks++;
      if (saw_ack !== 1'b0) $display("FAIL reset_mid stray activity got=1 exp=0");
      else passed++;
      txn(1'b0, 1'b0, 32'h20, 32'h0, "rd_0x20_after_reset");
   endtask

   task automatic test_back_to_back();
      logic        wr_v [4];
      logic [31:0] d_v  [4];
      logic [31:0] m4;
      logic [31:0] md0;
      exp_t        e;
      wr_v = '{1'b1, 1'b0, 1'b1, 1'b0};
      d_v  = '{32'h1, 32'h0, 32'h2, 32'h0};
      m4   = 32'hx;
      md0  = 32'd0;
      @(negedge clk);
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            checks++;
            if ({ack0, busy0, err0} !== 3'b110)
               $display("FAIL b2b[%0d] {ack,busy,err} got=%b exp=110", i - 1, {ack0, busy0, err0});
            else passed++;
            e = (sb0.size() > 0) ? sb0.pop_front() : '0;
            if (!e.wr) begin
               checks++;
               if (dout0 !== e.dout)
                  $display("FAIL b2b[%0d] read dout got=%h exp=%h", i - 1, dout0, e.dout);
               else passed++;
            end
         end
         if (i < 4) begin
            cs0 = 1'b0; we0 = wr_v[i]; oe0 = wr_v[i]; addr0 = 32'h4; din0 = d_v[i];
            if (wr_v[i]) m4 = d_v[i];
            else md0 = m4;
            sb0.push_back('{wr: wr_v[i], err: 1'b0, dout: md0});
         end else begin
            cs0 = 1'b1; we0 = 1'b0; oe0 = 1'b1;
         end
         @(negedge clk);
      end
      checks++;
      if ({ack0, busy0} !== 2'b00) $display("FAIL b2b idle got=%b exp=00", {ack0, busy0});
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_errors();
      test_write_priority();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() + sb0.size() !== 0)
         $display("FAIL scoreboard leftover got=%0d exp=0", sb.size() + sb0.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
